// File: rtl/alu16_pipe_if.sv
// Handshake and data bundle for alu16_pipe: upstream operand channel and
// downstream result channel, each with its own valid/ready pair.
interface alu16_pipe_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_y;
  logic [5:0]       ctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  // Environment side: offers operands, consumes results.
  modport master (
    output in_valid, in_x, in_y, ctrl, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  // ALU side: accepts operands, produces results.
  modport slave (
    input  in_valid, in_x, in_y, ctrl, out_ready,
    output in_ready, out_valid, out, zr, ng
  );
endinterface

// File: rtl/alu16_pipe.sv
// Hack-style ALU with two registered stages (operand capture, result) and
// valid/ready flow control on both sides. The f=0 path is a plain bitwise AND
// of the pre-conditioned operands.
module alu16_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu16_pipe_if.slave  bus
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic [5:0]       s1_ctrl;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_out;
  logic             s2_zr;
  logic             s2_ng;

  logic             s2_free;
  logic             accept;

  logic [WIDTH-1:0] x1, x2, y1, y2, r, res;

  // S2 can take new data when empty or when its result leaves this edge;
  // S1 can take new data when empty or when it moves into S2 this edge.
  always_comb begin
    s2_free = !s2_valid || bus.out_ready;
    accept  = bus.in_valid && (!s1_valid || s2_free);
  end

  assign bus.in_ready  = !s1_valid || s2_free;
  assign bus.out_valid = s2_valid;
  assign bus.out       = s2_out;
  assign bus.zr        = s2_zr;
  assign bus.ng        = s2_ng;

  // Operand conditioning and function select on the S1 contents.
  always_comb begin
    x1  = s1_ctrl[5] ? '0 : s1_x;
    x2  = s1_ctrl[4] ? ~x1 : x1;
    y1  = s1_ctrl[3] ? '0 : s1_y;
    y2  = s1_ctrl[2] ? ~y1 : y1;
    r   = s1_ctrl[1] ? (x2 + y2) : (x2 & y2);
    res = s1_ctrl[0] ? ~r : r;
  end

  // Stage 1: capture accepted operands; empties when it moves on with nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_ctrl  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_x     <= bus.in_x;
      s1_y     <= bus.in_y;
      s1_ctrl  <= bus.ctrl;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: register result and flags; holds steady while stalled downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_out   <= '0;
      s2_zr    <= 1'b0;
      s2_ng    <= 1'b0;
    end else if (s2_free) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_out <= res;
        s2_zr  <= (res == '0);
        s2_ng  <= res[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_alu16_pipe.sv
// Bench for alu16_pipe: directed vectors, streaming, backpressure, reset
// mid-stream and a randomized phase, all checked against a queue-based model.
module tb_alu16_pipe;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu16_pipe_if #(.WIDTH(16)) bus ();

  alu16_pipe #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  logic [17:0] exp_q[$];   // {zr, ng, out} in acceptance order

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU computed with integer arithmetic on the control rules.
  function automatic logic [17:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                          input logic [5:0] c);
    int unsigned xv, yv, rv;
    xv = c[5] ? 0 : int'(x);
    if (c[4]) xv = 65535 - xv;
    yv = c[3] ? 0 : int'(y);
    if (c[2]) yv = 65535 - yv;
    rv = c[1] ? (xv + yv) % 65536 : (xv & yv);
    if (c[0]) rv = 65535 - rv;
    return {rv == 0, rv >= 32768, 16'(rv)};
  endfunction

  // Transfers are committed at the next rising edge; inputs change only just
  // after rising edges, so the falling edge sees exactly what will transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid && bus.out_ready) begin
        chk("model_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          chk("result", {14'd0, bus.zr, bus.ng, bus.out}, {14'd0, exp_q.pop_front()});
        n_out++;
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_alu(bus.in_x, bus.in_y, bus.ctrl));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic rand_data();
    bus.in_x = 16'($urandom);
    bus.in_y = 16'($urandom);
    bus.ctrl = 6'($urandom);
  endtask

  task automatic send_one(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic [5:0] c, input logic [15:0] eo,
                          input logic ez, input logic en);
    bus.in_x = x; bus.in_y = y; bus.ctrl = c;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk) chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk) #1 bus.in_valid = 1'b0;
    @(negedge clk) chk({tag, "_not_yet"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_out"},   32'(bus.out), 32'(eo));
    chk({tag, "_zr"},    32'(bus.zr), 32'(ez));
    chk({tag, "_ng"},    32'(bus.ng), 32'(en));
    @(posedge clk) #1;
  endtask

  task automatic drain(input string tag);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk) #1;
  endtask

  initial begin
    int acc, idx, base;
    logic took, have_snap;
    logic [17:0] snap;
    logic [15:0] bx[4];
    logic [15:0] by[4];
    logic [5:0]  bc[4];

    // Reset with inputs toggling.
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.ctrl = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk) #1;
      rand_data();
      bus.in_valid  = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out", 32'(bus.out), 32'd0);
      chk("rst_zr", 32'(bus.zr), 32'd0);
      chk("rst_ng", 32'(bus.ng), 32'd0);
    end
    bus.in_valid = 1'b0;
    @(posedge clk) #1 rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk) #1;

    // Directed vectors.
    send_one("and_ffff", 16'h02F3, 16'hFFFF, 6'b000000, 16'h02F3, 1'b0, 1'b0);
    send_one("and_zero", 16'h02F3, 16'h0000, 6'b000000, 16'h0000, 1'b1, 1'b0);
    send_one("add_ovf",  16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1);
    send_one("x_minus_y", 16'h0005, 16'h0003, 6'b010011, 16'h0002, 1'b0, 1'b0);
    send_one("minus_one", 16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
    send_one("zero",      16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0);

    // Streaming: 8 back-to-back items, results on consecutive cycles.
    base = n_out;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      bus.in_valid = (k < 8);
      rand_data();
      @(negedge clk);
      chk($sformatf("stream_valid_%0d", k), 32'(bus.out_valid), 32'((k >= 2) && (k <= 9)));
      @(posedge clk) #1;
    end
    bus.in_valid = 1'b0;
    chk("stream_count", 32'(n_out - base), 32'd8);

    // Backpressure: 4 offered while stalled for 5 cycles.
    base = n_out;
    for (int i = 0; i < 4; i++) begin
      bx[i] = 16'($urandom); by[i] = 16'($urandom); bc[i] = 6'($urandom);
    end
    bus.out_ready = 1'b0;
    acc = 0; idx = 0; have_snap = 1'b0; snap = '0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      bus.in_valid = (idx < 4);
      if (idx < 4) begin bus.in_x = bx[idx]; bus.in_y = by[idx]; bus.ctrl = bc[idx]; end
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) acc++;
      if (bus.out_valid) begin
        if (!have_snap) begin snap = {bus.zr, bus.ng, bus.out}; have_snap = 1'b1; end
        else chk("bp_out_stable", {14'd0, bus.zr, bus.ng, bus.out}, {14'd0, snap});
      end
      @(posedge clk) #1;
      if (took) idx++;
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    @(negedge clk) chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
    @(posedge clk) #1;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && idx < 4; cyc++) begin
      bus.in_valid = 1'b1;
      bus.in_x = bx[idx]; bus.in_y = by[idx]; bus.ctrl = bc[idx];
      @(negedge clk);
      took = bus.in_ready;
      @(posedge clk) #1;
      if (took) idx++;
    end
    chk("bp_all_accepted", 32'(idx), 32'd4);
    drain("bp");
    chk("bp_count", 32'(n_out - base), 32'd4);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; rand_data();
    @(posedge clk) #1 rand_data();
    @(posedge clk) #1 bus.in_valid = 1'b0;
    @(negedge clk) chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out", 32'(bus.out), 32'd0);
    chk("midrst_flags", {30'd0, bus.zr, bus.ng}, 32'd0);
    exp_q.delete();
    base = n_out;
    @(posedge clk) #1;
    @(posedge clk) #1 rst_n = 1'b1;
    #1 chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk) chk("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
    chk("midrst_no_ghost_count", 32'(n_out - base), 32'd0);
    @(posedge clk) #1;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1; rand_data();
      @(posedge clk) #1;
    end
    drain("midrst");
    chk("midrst_count", 32'(n_out - base), 32'd3);

    // Randomized traffic with random backpressure.
    base = n_out; acc = 0; took = 1'b0;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.in_valid || took) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        rand_data();
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) acc++;
      @(posedge clk) #1;
    end
    drain("rand");
    chk("rand_count", 32'(n_out - base), 32'(acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
